// File: rtl/cpu_core_p.sv
// Parametrised multi-cycle CPU core: FETCH / EXEC / MEM / HALT sequencing with
// req/ack instruction and data memory ports, carry and zero flags.
module cpu_core_p #(
    parameter int unsigned DW   = 16,
    parameter int unsigned AW   = 16,
    parameter int unsigned NREG = 4
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [15:0]   imem_data,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          halted,
    output logic [AW-1:0] o_pc,
    output logic [15:0]   o_ir,
    output logic [1:0]    o_flags
);

    localparam int unsigned IW = 16;
    localparam int unsigned RW = $clog2(NREG);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_NOT  = 4'hA;
    localparam logic [3:0] OP_LD   = 4'hB;
    localparam logic [3:0] OP_ST   = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [AW-1:0] pc;
    logic [IW-1:0] ir;
    logic [DW-1:0] regs [NREG];
    logic          flag_c;
    logic          flag_z;

    logic [3:0]    op;
    logic [RW-1:0] rd_idx;
    logic [RW-1:0] rs_idx;
    logic [7:0]    imm8;
    logic [DW-1:0] rd_val;
    logic [DW-1:0] rs_val;
    logic [AW-1:0] rs_addr;
    logic [DW:0]   sum;
    logic [DW:0]   diff;

    logic [DW-1:0] alu_res;
    logic          alu_c;
    logic          alu_z;
    logic          alu_wr;

    logic          fetch_done;
    logic          mem_done;
    logic          is_mem_op;

    logic          imem_req_d;
    logic          dmem_req_d;
    logic          dmem_we_d;
    logic [AW-1:0] dmem_addr_d;
    logic [DW-1:0] dmem_wdata_d;
    logic          halted_d;

    // Instruction field decode; register reads see every earlier write-back
    assign op        = ir[15:12];
    assign rd_idx    = ir[8 +: RW];
    assign rs_idx    = ir[4 +: RW];
    assign imm8      = ir[7:0];
    assign rd_val    = regs[rd_idx];
    assign rs_val    = regs[rs_idx];
    assign rs_addr   = AW'(rs_val);
    assign sum       = (DW+1)'(rd_val) + (DW+1)'(rs_val);
    assign diff      = (DW+1)'(rd_val) - (DW+1)'(rs_val);
    assign is_mem_op = (op == OP_LD) || (op == OP_ST);

    assign fetch_done = imem_req && imem_ack;
    assign mem_done   = dmem_req && dmem_ack;

    assign imem_addr = pc;
    assign o_pc      = pc;
    assign o_ir      = ir;
    assign o_flags   = {flag_c, flag_z};

    // ALU: rd = rd op rs, with the flag results each opcode defines
    always_comb begin
        alu_res = rd_val;
        alu_c   = flag_c;
        alu_z   = flag_z;
        alu_wr  = 1'b0;
        case (op)
            OP_LDI: begin
                alu_res = DW'(imm8);
                alu_wr  = 1'b1;
            end
            OP_MOV: begin
                alu_res = rs_val;
                alu_wr  = 1'b1;
            end
            OP_ADD: begin
                alu_res = sum[DW-1:0];
                alu_c   = sum[DW];
                alu_wr  = 1'b1;
            end
            OP_SUB: begin
                alu_res = diff[DW-1:0];
                alu_c   = diff[DW];
                alu_wr  = 1'b1;
            end
            OP_AND: begin
                alu_res = rd_val & rs_val;
                alu_c   = 1'b0;
                alu_wr  = 1'b1;
            end
            OP_OR: begin
                alu_res = rd_val | rs_val;
                alu_c   = 1'b0;
                alu_wr  = 1'b1;
            end
            OP_XOR: begin
                alu_res = rd_val ^ rs_val;
                alu_c   = 1'b0;
                alu_wr  = 1'b1;
            end
            OP_SHL: begin
                alu_res = {rd_val[DW-2:0], 1'b0};
                alu_c   = rd_val[DW-1];
                alu_wr  = 1'b1;
            end
            OP_SHR: begin
                alu_res = {1'b0, rd_val[DW-1:1]};
                alu_c   = rd_val[0];
                alu_wr  = 1'b1;
            end
            OP_NOT: begin
                alu_res = ~rd_val;
                alu_c   = 1'b0;
                alu_wr  = 1'b1;
            end
            default: begin
                alu_res = rd_val;
            end
        endcase
        if (op >= OP_ADD && op <= OP_NOT) begin
            alu_z = (alu_res == '0);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (fetch_done) begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_mem_op) begin
                    next_state = S_MEM;
                end else if (op == OP_HALT) begin
                    next_state = S_HALT;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_MEM: begin
                if (mem_done) begin
                    next_state = S_FETCH;
                end
            end
            default: begin
                next_state = S_HALT;
            end
        endcase
    end

    // Output logic: next values of the registered bus outputs
    always_comb begin
        imem_req_d   = (next_state == S_FETCH);
        dmem_req_d   = (next_state == S_MEM);
        dmem_we_d    = dmem_we && dmem_req_d;
        dmem_addr_d  = dmem_addr;
        dmem_wdata_d = dmem_wdata;
        halted_d     = halted;
        if (state == S_EXEC) begin
            if (is_mem_op) begin
                dmem_addr_d  = rs_addr;
                dmem_wdata_d = rd_val;
                dmem_we_d    = (op == OP_ST);
            end
            if (op == OP_HALT) begin
                halted_d = 1'b1;
            end
        end
    end

    // Bus output registers; the data-side fields stay frozen while the access stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            halted     <= 1'b0;
        end else begin
            imem_req   <= imem_req_d;
            dmem_req   <= dmem_req_d;
            dmem_we    <= dmem_we_d;
            dmem_addr  <= dmem_addr_d;
            dmem_wdata <= dmem_wdata_d;
            halted     <= halted_d;
        end
    end

    // Architectural state: PC, IR, register file, flags
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= '0;
            ir     <= '0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (fetch_done) begin
                        ir <= imem_data;
                        pc <= pc + AW'(1);
                    end
                end
                S_EXEC: begin
                    if (alu_wr) begin
                        regs[rd_idx] <= alu_res;
                    end
                    flag_c <= alu_c;
                    flag_z <= alu_z;
                    if (op == OP_JMP || (op == OP_JZ && flag_z)) begin
                        pc <= rs_addr;
                    end
                end
                S_MEM: begin
                    if (mem_done && !dmem_we) begin
                        regs[rd_idx] <= dmem_rdata;
                        flag_c       <= 1'b0;
                        flag_z       <= (dmem_rdata == '0);
                    end
                end
                default: begin
                    pc <= pc;
                end
            endcase
        end
    end

endmodule
